// File: rtl/pulse_sequencer.sv
`default_nettype none
// ==== pulse_sequencer : CPMG/Hahn/CW pulse sequencer, config shadowed at shot boundaries ====
// ==== Rev 1.0 ====
module pulse_sequencer #(
   parameter int CW       = 32,
   parameter int NP       = 16,
   parameter int AW       = 7,
   parameter int ATT_LEAD = 30,
   parameter int CW_SYNC  = 50
) (
   input  logic          clk_pll,
   input  logic          reset,
   input  logic          enable,
   input  logic          pump,
   input  logic [CW-1:0] period,
   input  logic [CW-1:0] p1width,
   input  logic [CW-1:0] delay,
   input  logic [CW-1:0] p2width,
   input  logic [7:0]    npulse,
   input  logic [15:0]   pulse_block,
   input  logic [15:0]   pulse_block_off,
   input  logic          block,
   input  logic [AW-1:0] pre_att,
   input  logic [AW-1:0] post_att,
   output logic          sync_on,
   output logic          pulse_on,
   output logic          inhib,
   output logic [AW-1:0] Att1,
   output logic [AW-1:0] Att3,
   output logic [7:0]    pulse_idx,
   output logic          shot_done,
   output logic          busy
);

   localparam int TW = CW + 2;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   typedef struct packed {
      logic [CW-1:0] per;
      logic [CW-1:0] p1w;
      logic [CW-1:0] dly;
      logic [CW-1:0] p2w;
      logic [7:0]    np;
      logic [15:0]   pb;
      logic [15:0]   pbo;
      logic          blk;
      logic          pump;
      logic [AW-1:0] pre;
      logic [AW-1:0] post;
   } cfg_t;

   function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] a, input logic [TW-1:0] b);
      logic [TW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[TW] ? {TW{1'b1}} : s[TW-1:0];
   endfunction

   state_t        state_q, state_d;
   cfg_t          cfg_q, cfg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    pk_q, pk_d, wk_q, wk_d;
   logic [TW-1:0] pnx_q, pnx_d, pls_q, pls_d, wnx_q, wnx_d, wls_q, wls_d;
   logic          sync_on_q, sync_on_d, pulse_on_q, pulse_on_d, inhib_q, inhib_d;
   logic          shot_done_q, shot_done_d, busy_q, busy_d;
   logic [AW-1:0] att1_q, att1_d, att3_q, att3_d;
   logic [7:0]    pulse_idx_q, pulse_idx_d;

   logic          boundary, restart;
   logic [TW-1:0] per_x, cnt_x, p2w_x, pbo_x;
   logic [TW-1:0] s1, step, o_off, c_off, o1;
   logic [CW-1:0] sync_start;

   assign boundary   = (state_q == S_RUN) && (cnt_q == cfg_q.per);
   assign restart    = (state_q == S_IDLE) || boundary;
   assign per_x      = TW'(cfg_q.per);
   assign cnt_x      = TW'(cnt_q);
   assign p2w_x      = TW'(cfg_q.p2w);
   assign pbo_x      = TW'(cfg_q.pbo);
   assign s1         = sat_add(TW'(cfg_q.p1w), TW'(cfg_q.dly));
   assign step       = sat_add(sat_add(TW'(cfg_q.dly), TW'(cfg_q.dly)), p2w_x);
   assign o_off      = sat_add(p2w_x, TW'(cfg_q.pb));
   assign c_off      = sat_add(o_off, pbo_x);
   assign o1         = sat_add(s1, o_off);
   assign sync_start = (cfg_q.per > CW'(CW_SYNC)) ? cfg_q.per - CW'(CW_SYNC) : '0;

   // Shadows reload during reset, every idle cycle and at each shot boundary
   always_comb begin
      cfg_d = cfg_q;
      if (reset || restart) begin
         cfg_d.per  = period;
         cfg_d.p1w  = p1width;
         cfg_d.dly  = delay;
         cfg_d.p2w  = p2width;
         cfg_d.np   = (npulse > 8'(NP)) ? 8'(NP) : npulse;
         cfg_d.pb   = pulse_block;
         cfg_d.pbo  = pulse_block_off;
         cfg_d.blk  = block;
         cfg_d.pump = pump;
         cfg_d.pre  = pre_att;
         cfg_d.post = post_att;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (state_q == S_IDLE) begin
         if (enable) state_d = S_RUN;
      end else if (boundary) begin
         state_d = enable ? S_RUN : S_IDLE;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Event trackers: each remembers the most recent start reached this shot and
   // the next start; equal widths mean the latest start always closes last.
   logic          p_take, p_have, w_take, w_have, w_act, w_lead;
   logic [TW-1:0] p_nxt, p_last, w_nxt, w_last, w_nxt_after;
   logic [7:0]    p_k, w_k;

   always_comb begin
      p_nxt  = (pk_q == 8'd0) ? s1 : pnx_q;
      p_take = (pk_q < cfg_q.np) && (p_nxt <= cnt_x) && (p_nxt < per_x);
      p_have = p_take || (pk_q != 8'd0);
      p_last = p_take ? p_nxt : pls_q;
      p_k    = p_take ? pk_q + 8'd1 : pk_q;

      w_nxt  = (wk_q == 8'd0) ? o1 : wnx_q;
      w_take = (wk_q < cfg_q.np) && (w_nxt <= cnt_x) && (w_nxt < per_x);
      w_have = w_take || (wk_q != 8'd0);
      w_last = w_take ? w_nxt : wls_q;
      w_k    = w_take ? wk_q + 8'd1 : wk_q;
      w_nxt_after = w_take ? sat_add(w_nxt, step) : w_nxt;

      w_act  = w_have && (cnt_x < sat_add(w_last, pbo_x));
      w_lead = (w_k < cfg_q.np) && (w_nxt_after < per_x) &&
               (w_nxt_after <= sat_add(cnt_x, TW'(ATT_LEAD)));

      pk_d  = restart ? 8'd0 : p_k;
      pnx_d = p_take ? sat_add(p_nxt, step) : pnx_q;
      pls_d = p_last;
      wk_d  = restart ? 8'd0 : w_k;
      wnx_d = w_take ? w_nxt_after : wnx_q;
      wls_d = w_last;
   end

   always_comb begin
      sync_on_d   = 1'b0;
      pulse_on_d  = 1'b0;
      inhib_d     = cfg_q.blk;
      att1_d      = cfg_q.pre;
      att3_d      = cfg_q.post;
      pulse_idx_d = 8'd0;
      shot_done_d = 1'b0;
      busy_d      = 1'b0;
      if (state_q == S_RUN) begin
         busy_d      = 1'b1;
         shot_done_d = boundary;
         if (cfg_q.np == 8'd0) begin
            pulse_on_d = 1'b1;
            inhib_d    = 1'b0;
            sync_on_d  = (cnt_q >= sync_start);
         end else begin
            sync_on_d = (cnt_x < o1);
            if (cnt_q < cfg_q.p1w)
               pulse_on_d = cfg_q.pump;
            else
               pulse_on_d = p_have && (cnt_x < sat_add(p_last, p2w_x));
            if (p_have && (cnt_x < sat_add(p_last, c_off)))
               pulse_idx_d = p_k;
            if (w_act)
               inhib_d = 1'b0;
            if (w_act || w_lead)
               att3_d = '0;
         end
      end
   end

   always_ff @(posedge clk_pll) begin
      cfg_q <= cfg_d;
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pk_q        <= '0;
         pnx_q       <= '0;
         pls_q       <= '0;
         wk_q        <= '0;
         wnx_q       <= '0;
         wls_q       <= '0;
         sync_on_q   <= 1'b0;
         pulse_on_q  <= 1'b0;
         inhib_q     <= 1'b0;
         att1_q      <= '0;
         att3_q      <= '0;
         pulse_idx_q <= '0;
         shot_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pk_q        <= pk_d;
         pnx_q       <= pnx_d;
         pls_q       <= pls_d;
         wk_q        <= wk_d;
         wnx_q       <= wnx_d;
         wls_q       <= wls_d;
         sync_on_q   <= sync_on_d;
         pulse_on_q  <= pulse_on_d;
         inhib_q     <= inhib_d;
         att1_q      <= att1_d;
         att3_q      <= att3_d;
         pulse_idx_q <= pulse_idx_d;
         shot_done_q <= shot_done_d;
         busy_q      <= busy_d;
      end
   end

   assign sync_on   = sync_on_q;
   assign pulse_on  = pulse_on_q;
   assign inhib     = inhib_q;
   assign Att1      = att1_q;
   assign Att3      = att3_q;
   assign pulse_idx = pulse_idx_q;
   assign shot_done = shot_done_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ==== tb_pulse_sequencer : directed + randomized bench against an event-list reference model ====
// ==== Rev 1.0 ====
module tb_pulse_sequencer;

   localparam int CW = 32, NP = 16, AW = 7, ATT_LEAD = 30, CW_SYNC = 50;
   localparam longint SATV = (64'sd1 <<< (CW + 2)) - 1;

   logic          clk_pll = 1'b0;
   logic          reset, enable, pump, block;
   logic [CW-1:0] period, p1width, delay, p2width;
   logic [7:0]    npulse;
   logic [15:0]   pulse_block, pulse_block_off;
   logic [AW-1:0] pre_att, post_att;
   logic          sync_on, pulse_on, inhib, shot_done, busy;
   logic [AW-1:0] Att1, Att3;
   logic [7:0]    pulse_idx;

   always #5 clk_pll = ~clk_pll;

   pulse_sequencer #(.CW(CW), .NP(NP), .AW(AW), .ATT_LEAD(ATT_LEAD), .CW_SYNC(CW_SYNC)) dut (
      .clk_pll(clk_pll), .reset(reset), .enable(enable), .pump(pump),
      .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
      .npulse(npulse), .pulse_block(pulse_block), .pulse_block_off(pulse_block_off),
      .block(block), .pre_att(pre_att), .post_att(post_att),
      .sync_on(sync_on), .pulse_on(pulse_on), .inhib(inhib), .Att1(Att1), .Att3(Att3),
      .pulse_idx(pulse_idx), .shot_done(shot_done), .busy(busy)
   );

   int checks = 0, errors = 0;
   longint cyc = 0;

   // model state: run flag, counter and shadow copy of the configuration
   bit     m_run = 0;
   longint m_cnt = 0, m_per, m_p1w, m_dly, m_p2w, m_np, m_pb, m_pbo, m_pre, m_post;
   bit     m_blk, m_pump;
   bit     last_run = 0;
   longint last_c = 0;
   bit     e_sync, e_pulse, e_inhib, e_done, e_busy;
   longint e_att1, e_att3, e_idx;

   function automatic longint sat(input longint x);
      return (x > SATV) ? SATV : x;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input longint exp);
      checks++;
      if (act !== 64'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, counter %0d)", nm, act, exp, cyc, last_c);
      end
   endtask

   task automatic load_shadows();
      m_per = period; m_p1w = p1width; m_dly = delay; m_p2w = p2width;
      m_np = (npulse > NP) ? NP : npulse;
      m_pb = pulse_block; m_pbo = pulse_block_off; m_blk = block; m_pump = pump;
      m_pre = pre_att; m_post = post_att;
   endtask

   // Outputs for a running shot at counter c, straight from the event-time formulas
   task automatic model_run(input longint c);
      longint s, e, o, cl, lead, o1;
      e_pulse = 0; e_inhib = m_blk; e_att3 = m_post; e_idx = 0; o1 = 0;
      if (m_np == 0) begin
         e_pulse = 1; e_inhib = 0;
         e_sync  = (c >= ((m_per > CW_SYNC) ? m_per - CW_SYNC : 0));
      end else begin
         for (int k = 1; k <= m_np; k++) begin
            s  = sat(m_p1w + m_dly + (k - 1) * (2 * m_dly + m_p2w));
            e  = sat(s + m_p2w);
            o  = sat(e + m_pb);
            cl = sat(o + m_pbo);
            lead = (o > ATT_LEAD) ? o - ATT_LEAD : 0;
            if (k == 1) o1 = o;
            if (s < m_per && s <= c && c < e)     e_pulse = 1;
            if (s < m_per && s <= c && c < cl)    e_idx = k;
            if (o < m_per && o <= c && c < cl)    e_inhib = 0;
            if (o < m_per && lead <= c && c < cl) e_att3 = 0;
         end
         if (c < m_p1w) e_pulse = m_pump;
         e_sync = (c < o1);
      end
   endtask

   task automatic step();
      if (reset) begin
         e_sync = 0; e_pulse = 0; e_inhib = 0; e_att1 = 0; e_att3 = 0; e_idx = 0; e_done = 0; e_busy = 0;
         load_shadows(); m_run = 0; m_cnt = 0; last_run = 0;
      end else if (!m_run) begin
         e_sync = 0; e_pulse = 0; e_inhib = m_blk; e_att1 = m_pre; e_att3 = m_post;
         e_idx = 0; e_done = 0; e_busy = 0;
         load_shadows(); m_run = enable; m_cnt = 0; last_run = 0;
      end else begin
         model_run(m_cnt);
         e_busy = 1; e_att1 = m_pre; e_done = (m_cnt == m_per);
         last_run = 1; last_c = m_cnt;
         if (m_cnt == m_per) begin
            load_shadows(); m_cnt = 0; m_run = enable;
         end else m_cnt++;
      end
      @(negedge clk_pll);
      cyc++;
      chk("sync_on", sync_on, e_sync);
      chk("pulse_on", pulse_on, e_pulse);
      chk("inhib", inhib, e_inhib);
      chk("Att1", Att1, e_att1);
      chk("Att3", Att3, e_att3);
      chk("pulse_idx", pulse_idx, e_idx);
      chk("shot_done", shot_done, e_done);
      chk("busy", busy, e_busy);
   endtask

   task automatic run_until(input longint c, input int budget);
      int n = 0;
      do begin step(); n++; end while (!(last_run && last_c == c) && n < budget);
      checks++;
      if (!(last_run && last_c == c)) begin
         errors++;
         $display("FAIL run_until: counter %0d not reached, got %0d", c, last_c);
      end
   endtask

   task automatic run_shots(input int nshots, input int budget);
      int n = 0, seen = 0;
      while (seen < nshots && n < budget) begin
         step(); n++;
         if (e_done) seen++;
      end
      checks++;
      if (seen < nshots) begin
         errors++;
         $display("FAIL run_shots: saw %0d shot ends, required %0d", seen, nshots);
      end
   endtask

   task automatic set_cfg(input longint per, input longint p1, input longint d, input longint p2,
                          input longint np, input longint pb, input longint pbo);
      period = CW'(per); p1width = CW'(p1); delay = CW'(d); p2width = CW'(p2);
      npulse = 8'(np); pulse_block = 16'(pb); pulse_block_off = 16'(pbo);
   endtask

   task automatic rand_cfg();
      set_cfg($urandom_range(30, 400), $urandom_range(0, 40), $urandom_range(1, 60),
              $urandom_range(0, 30), ($urandom_range(0, 7) == 0) ? 200 : $urandom_range(0, 20),
              $urandom_range(0, 20), $urandom_range(0, 60));
      block = 1'($urandom); pump = 1'($urandom);
      pre_att = AW'($urandom); post_att = AW'($urandom);
   endtask

   initial begin
      longint t0, cnt_on;

      // model pins for the Hahn / CPMG / CW cases
      m_per = 999; m_p1w = 20; m_dly = 100; m_p2w = 40; m_np = 1; m_pb = 10; m_pbo = 50;
      m_blk = 1; m_pump = 1; m_pre = 3; m_post = 5;
      model_run(19);  chk("pin_pulse19", e_pulse, 1);
      model_run(20);  chk("pin_pulse20", e_pulse, 0);
      model_run(159); chk("pin_pulse159", e_pulse, 1);
      model_run(169); chk("pin_sync169", e_sync, 1);
      model_run(170); chk("pin_inhib170", e_inhib, 0);
      model_run(139); chk("pin_att3_139", e_att3, 5);
      model_run(140); chk("pin_att3_140", e_att3, 0);
      m_np = 3;
      model_run(600); chk("pin_idx600", e_idx, 3);
      m_np = 0;
      model_run(948); chk("pin_cw_sync948", e_sync, 0);
      model_run(949); chk("pin_cw_sync949", e_sync, 1);

      // reset with Hahn settings
      reset = 1; enable = 1; pump = 1; block = 1; pre_att = 3; post_att = 5;
      set_cfg(999, 20, 100, 40, 1, 10, 50);
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_inhib", inhib, 0);
      reset = 0;

      // Hahn
      run_until(120, 2000);
      chk("hahn_pulse120", pulse_on, 1);
      run_shots(1, 2000);
      t0 = cyc;
      run_shots(1, 2000);
      chk("hahn_shot_len", cyc - t0, 1000);

      // CPMG
      set_cfg(999, 20, 100, 40, 3, 10, 50);
      run_shots(1, 2000);
      run_until(600, 2000);
      chk("cpmg_idx600", pulse_idx, 3);
      run_shots(1, 2000);

      // clamp: 200 requested, NP pi pulses of 40 cycles fit in a long shot
      set_cfg(4999, 20, 100, 40, 200, 10, 50);
      run_shots(1, 6000);
      cnt_on = 0;
      for (int i = 0; i < 5000; i++) begin
         step();
         if (pulse_on === 1'b1 && last_c >= 20) cnt_on++;
      end
      chk("clamp_pi_cycles", cnt_on, NP * 40);

      // truncation
      set_cfg(400, 20, 100, 40, 200, 10, 50);
      run_shots(3, 6000);

      // CW
      set_cfg(999, 20, 100, 40, 0, 10, 50);
      run_shots(1, 2000);
      run_until(949, 2000);
      chk("cw_sync949", sync_on, 1);
      run_shots(1, 2000);

      // shadowing: delay change mid-shot only affects the next shot
      set_cfg(999, 20, 100, 40, 1, 10, 50);
      run_shots(1, 2000);
      run_until(300, 2000);
      delay = 50;
      run_shots(1, 2000);
      run_until(70, 2000);
      chk("shadow_pulse70", pulse_on, 1);

      // enable drop mid-shot, then reset mid-shot
      run_until(500, 2000);
      enable = 0;
      run_shots(1, 2000);
      step(); step();
      chk("ctl_busy_idle", busy, 0);
      chk("ctl_pulse_idle", pulse_on, 0);
      enable = 1;
      run_until(500, 2000);
      reset = 1;
      step();
      chk("ctl_rst_sync", sync_on, 0);
      chk("ctl_rst_busy", busy, 0);
      reset = 0;

      // randomized configurations with mid-shot changes and control events
      for (int n = 0; n < 40; n++) begin
         int ncyc;
         rand_cfg();
         ncyc = 2 * (int'(period) + 1) + 20;
         for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(0, 99) == 0) rand_cfg();
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            reset = ($urandom_range(0, 1999) == 0);
            step();
         end
         reset = 0; enable = 1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
